// File: rtl/risky_mem_arbiter_if.sv
// Requester-side signal bundle for risky_mem_arbiter: two request ports plus bus_err.
// Purely combinational wiring; the arbiter is the slave and the requesters are the master.
// A requester holds req with addr/we/wdata stable until it sees its one-cycle ack.
interface risky_mem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic        bus_err;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_rdata, m0_ack, m1_rdata, m1_ack, bus_err
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack, bus_err
  );
endinterface

// File: rtl/risky_mem_arbiter.sv
// Two-master arbiter/sequencer for the shared risky memory bus (ROM 0x00.., RAM 0x04..).
// Latency: ack 2+W cycles after req is seen in IDLE (W = region wait, 0 for faults).
// Backpressure: one transaction in flight; the losing requester holds req until acked.
// Option macro RISKY_ARB_FIXED_PRIO_EN: fixed m0 priority instead of round-robin.
module risky_mem_arbiter #(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  risky_mem_arbiter_if.slave req_bus,
  inout  wire  [31:0]        mem_data,
  output logic [31:0]        mem_addr,
  output logic               mem_oe,
  output logic               mem_we
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Latched transaction
  logic        cur;
  logic        we_l;
  logic [31:0] addr_l;
  logic [31:0] wdata_l;
  logic [31:0] rdata_l;
  logic [3:0]  wait_cnt;
`ifndef RISKY_ARB_FIXED_PRIO_EN
  logic        last_gnt;
`endif

  // Winner of the current IDLE cycle
  logic        any_req;
  logic        gnt;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [3:0]  win_wait;

  // Decode of the latched transaction
  logic        rom_hit;
  logic        ram_hit;
  logic        fault;
  logic        drive;

  assign rom_hit = (addr_l[31:26] == 6'd0);
  assign ram_hit = (addr_l[31:26] == 6'd1);
  // Unmapped space and ROM writes never touch the bus
  assign fault   = !(rom_hit || ram_hit) || (we_l && rom_hit);

  // Pick the winner and fetch its request fields and wait-state count
  always_comb begin
    any_req = req_bus.m0_req | req_bus.m1_req;
`ifdef RISKY_ARB_FIXED_PRIO_EN
    gnt = ~req_bus.m0_req;
`else
    gnt = (req_bus.m0_req & req_bus.m1_req) ? ~last_gnt : req_bus.m1_req;
`endif
    win_we    = gnt ? req_bus.m1_we    : req_bus.m0_we;
    win_addr  = gnt ? req_bus.m1_addr  : req_bus.m0_addr;
    win_wdata = gnt ? req_bus.m1_wdata : req_bus.m0_wdata;
    // Faulting accesses spend exactly one cycle in ACCESS
    win_wait  = 4'd0;
    if (win_addr[31:26] == 6'd0 && !win_we) begin
      win_wait = 4'(ROM_WAIT);
    end else if (win_addr[31:26] == 6'd1) begin
      win_wait = 4'(RAM_WAIT);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Transaction latch, wait counter and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= 1'b0;
      we_l     <= 1'b0;
      addr_l   <= 32'd0;
      wdata_l  <= 32'd0;
      rdata_l  <= 32'd0;
      wait_cnt <= 4'd0;
`ifndef RISKY_ARB_FIXED_PRIO_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cur      <= gnt;
            we_l     <= win_we;
            addr_l   <= win_addr;
            wdata_l  <= win_wdata;
            wait_cnt <= win_wait;
            rdata_l  <= 32'd0;
`ifndef RISKY_ARB_FIXED_PRIO_EN
            last_gnt <= gnt;
`endif
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (!we_l && !fault) begin
            rdata_l <= mem_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus strobes, bus address and the per-requester response
  always_comb begin
    drive            = 1'b0;
    mem_oe           = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = 32'd0;
    req_bus.m0_ack   = 1'b0;
    req_bus.m1_ack   = 1'b0;
    req_bus.m0_rdata = 32'd0;
    req_bus.m1_rdata = 32'd0;
    req_bus.bus_err  = 1'b0;
    if (state == ACCESS) begin
      mem_addr = addr_l;
      if (!fault) begin
        drive  = we_l;
        mem_oe = !we_l;
        // Single write strobe in the last ACCESS cycle
        mem_we = we_l && (wait_cnt == 4'd0);
      end
    end
    if (state == RESP) begin
      req_bus.bus_err = fault;
      if (cur) begin
        req_bus.m1_ack   = 1'b1;
        req_bus.m1_rdata = rdata_l;
      end else begin
        req_bus.m0_ack   = 1'b1;
        req_bus.m0_rdata = rdata_l;
      end
    end
  end

  assign mem_data = drive ? wdata_l : 32'bz;

endmodule

// File: tb/tb_risky_mem_arbiter.sv
// Bench for risky_mem_arbiter: directed latency/fault/contention/reset-abort sequences,
// then random two-master traffic. Expected responses are queued per requester at issue
// time from a reference model and popped by an independent monitor on every ack.
module tb_risky_mem_arbiter;
  localparam int ROM_W = 1;
  localparam int RAM_W = 3;
  localparam int TMO   = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_init;
  wire  [31:0] mem_data;
  logic [31:0] mem_addr;
  logic        mem_oe;
  logic        mem_we;

  risky_mem_arbiter_if ifc();

  risky_mem_arbiter #(.ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_bus  (ifc),
    .mem_data (mem_data),
    .mem_addr (mem_addr),
    .mem_oe   (mem_oe),
    .mem_we   (mem_we)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory device on the shared bus ----------------
  function automatic logic [31:0] rom_img(input logic [31:0] a);
    if (a == 32'h4) return 32'hDEADBEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] ram [0:1023];
  logic [31:0] dev_rd;
  always_comb dev_rd = (mem_addr[31:26] == 6'd0) ? rom_img(mem_addr) : ram[mem_addr[9:0]];
  assign mem_data = mem_oe ? dev_rd : 32'bz;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'd0;
    end else if (mem_we) begin
      ram[mem_addr[9:0]] <= mem_data;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk_rd;
    int          oe_n;
    int          we_n;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] ref_ram [0:1023];

  function automatic exp_t model(input logic we, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.rdata = 32'd0; e.err = 1'b0; e.chk_rd = !we; e.oe_n = 0; e.we_n = 0;
    if (a[31:26] == 6'd0) begin
      if (we) e.err = 1'b1;
      else begin e.rdata = rom_img(a); e.oe_n = ROM_W + 1; end
    end else if (a[31:26] == 6'd1) begin
      if (we) begin ref_ram[a[9:0]] = wd; e.we_n = 1; end
      else begin e.rdata = ref_ram[a[9:0]]; e.oe_n = RAM_W + 1; end
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int oe_cnt = 0;
  int we_cnt = 0;
  int we_total = 0;
  int last_we_cyc = -1;
  int ack_m[$];
  int ack_c[$];

  task automatic handle(input int m, input logic [31:0] rd);
    exp_t e;
    bit   have;
    ack_m.push_back(m);
    ack_c.push_back(cyc);
    have = (m == 0) ? (q0.size() > 0) : (q1.size() > 0);
    chk($sformatf("ack_expected_m%0d", m), {31'd0, have}, 32'd1);
    if (have) begin
      if (m == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("bus_err_m%0d", m), {31'd0, ifc.bus_err}, {31'd0, e.err});
      if (e.chk_rd) chk($sformatf("rdata_m%0d", m), rd, e.rdata);
      chk($sformatf("oe_cycles_m%0d", m), 32'(oe_cnt), 32'(e.oe_n));
      chk($sformatf("we_cycles_m%0d", m), 32'(we_cnt), 32'(e.we_n));
      if (e.we_n == 1) chk($sformatf("we_last_access_m%0d", m), 32'(last_we_cyc), 32'(cyc - 1));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mem_we) we_total++;
      if (rst) begin
        oe_cnt = 0;
        we_cnt = 0;
      end else begin
        if (mem_oe) oe_cnt++;
        if (mem_we) begin we_cnt++; last_we_cyc = cyc; end
        if (ifc.m0_ack || ifc.m1_ack) begin
          chk("ack_exclusive", {31'd0, ifc.m0_ack & ifc.m1_ack}, 32'd0);
          if (ifc.m0_ack) handle(0, ifc.m0_rdata);
          if (ifc.m1_ack) handle(1, ifc.m1_rdata);
          oe_cnt = 0;
          we_cnt = 0;
        end else if (ifc.bus_err) begin
          chk("bus_err_without_ack", 32'd1, 32'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int m, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input bit hold, output int lat);
    logic ackd;
    if (m == 0) begin
      q0.push_back(model(we, a, wd));
      ifc.m0_we = we; ifc.m0_addr = a; ifc.m0_wdata = wd; ifc.m0_req = 1'b1;
    end else begin
      q1.push_back(model(we, a, wd));
      ifc.m1_we = we; ifc.m1_addr = a; ifc.m1_wdata = wd; ifc.m1_req = 1'b1;
    end
    lat  = 0;
    ackd = 1'b0;
    while (!ackd && lat < TMO) begin
      @(negedge clk);
      lat++;
      ackd = (m == 0) ? ifc.m0_ack : ifc.m1_ack;
    end
    chk($sformatf("ack_arrives_m%0d", m), {31'd0, ackd}, 32'd1);
    @(posedge clk); #1;
    if (!hold) begin
      if (m == 0) ifc.m0_req = 1'b0;
      else        ifc.m1_req = 1'b0;
    end
  endtask

  task automatic drive_rand(input int m, input logic [31:0] ram_base);
    int          kind;
    int          gap;
    int          lat;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < 40; i++) begin
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
      kind = $urandom_range(0, 9);
      wd   = $urandom;
      we   = 1'b0;
      case (kind)
        0, 1, 2: a = 32'($urandom_range(0, 255));
        3:       begin a = 32'($urandom_range(0, 255)); we = 1'b1; end
        4, 5, 6: a = ram_base + 32'($urandom_range(0, 15));
        7, 8:    begin a = ram_base + 32'($urandom_range(0, 15)); we = 1'b1; end
        default: begin
          a  = {5'($urandom_range(1, 31)), 27'($urandom)};
          we = 1'($urandom_range(0, 1));
        end
      endcase
      gap = $urandom_range(0, 2);
      issue(m, we, a, wd, (i < 39) && (gap == 0), lat);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int we_before;
    int n_log;
    int exp_seq[8];

    rst = 1'b1; mem_init = 1'b1;
    ifc.m0_req = 1'b0; ifc.m0_we = 1'b0; ifc.m0_addr = 32'd0; ifc.m0_wdata = 32'd0;
    ifc.m1_req = 1'b0; ifc.m1_we = 1'b0; ifc.m1_addr = 32'd0; ifc.m1_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) ref_ram[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {27'd0, ifc.m0_ack, ifc.m1_ack, ifc.bus_err, mem_oe, mem_we}, 32'd0);
    chk("reset_m0_rdata", ifc.m0_rdata, 32'd0);
    chk("reset_m1_rdata", ifc.m1_rdata, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_init = 1'b0;

    // Directed single transactions (uncontended): ack on the (3+W)-th negedge after req
    issue(0, 1'b0, 32'h0000_0004, 32'd0, 1'b0, lat);        chk("lat_rom_read", 32'(lat), 32'(ROM_W + 3));
    issue(1, 1'b1, 32'h0400_0010, 32'h1234_5678, 1'b0, lat); chk("lat_ram_write", 32'(lat), 32'(RAM_W + 3));
    issue(1, 1'b0, 32'h0400_0010, 32'd0, 1'b0, lat);        chk("lat_ram_read", 32'(lat), 32'(RAM_W + 3));
    issue(0, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 1'b0, lat); chk("lat_rom_write_fault", 32'(lat), 32'd3);
    issue(0, 1'b0, 32'h0800_0000, 32'd0, 1'b0, lat);        chk("lat_unmapped_read", 32'(lat), 32'd3);
    issue(1, 1'b1, 32'hF000_0040, 32'h1, 1'b0, lat);        chk("lat_unmapped_write", 32'(lat), 32'd3);

    // Reset during the first ACCESS cycle of a RAM write
    we_before = we_total;
    ifc.m1_we = 1'b1; ifc.m1_addr = 32'h0400_0020; ifc.m1_wdata = 32'hCAFE_F00D; ifc.m1_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; ifc.m1_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {27'd0, ifc.m0_ack, ifc.m1_ack, ifc.bus_err, mem_oe, mem_we}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_m1_rdata", ifc.m1_rdata, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_write", 32'(we_total - we_before), 32'd0);
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h0400_0020, 32'd0, 1'b0, lat);

    // Both requesters hold reads continuously for 4 transactions each
    n_log = ack_m.size();
`ifdef RISKY_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    fork
      for (int i = 0; i < 4; i++) begin
        int l;
        issue(0, 1'b0, 32'(32'h40 + i), 32'd0, (i < 3), l);
      end
      for (int j = 0; j < 4; j++) begin
        int l;
        issue(1, 1'b0, 32'(32'h80 + j), 32'd0, (j < 3), l);
      end
    join
    chk("contention_ack_count", 32'(ack_m.size() - n_log), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (n_log + k < ack_m.size()) begin
        chk($sformatf("contention_order_%0d", k), 32'(ack_m[n_log + k]), 32'(exp_seq[k]));
        if (k > 0)
          chk($sformatf("contention_spacing_%0d", k),
              32'(ack_c[n_log + k] - ack_c[n_log + k - 1]), 32'(ROM_W + 3));
      end
    end

    // Random traffic; each requester owns a disjoint RAM window
    fork
      drive_rand(0, 32'h0400_0100);
      drive_rand(1, 32'h0400_0200);
    join

    repeat (10) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/risky_mem_arbiter.md
# risky_mem_arbiter

Two-master arbiter and sequencer for the single shared risky memory bus (ROM at `addr[31:26]==0`, RAM at `addr[31:26]==1`). It sits between two requesters and the tristate `mem_data`/`mem_addr`/`mem_oe`/`mem_we` bus. Requester 0 is the core; requester 1 is a loader/debug/DMA port. The block grants one transaction at a time, inserts per-region wait states, drives or releases `mem_data`, and returns read data with a one-cycle ack.

## Interface
Parameters:
- `ROM_WAIT`, default 1: extra ACCESS cycles for the ROM region (0–15).
- `RAM_WAIT`, default 0: extra ACCESS cycles for the RAM region (0–15).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `m0_req`, `m1_req`  in  1  transaction request; held with address/we/wdata stable until ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  32  word address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_rdata`, `m1_rdata`  out  32  read data; valid only while the matching ack is high.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `bus_err`  out  1  one-cycle pulse coincident with ack for a faulted transaction.
- `mem_data`  inout  32  shared data bus.
- `mem_addr`  out  32  bus address.
- `mem_oe`  out  1  read enable.
- `mem_we`  out  1  write strobe.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If no request, stay in IDLE.
  - Otherwise pick a winner. Latch its addr/we/wdata and its index into `cur`.
  - Load the wait counter with `ROM_WAIT` or `RAM_WAIT` according to the region (0 for unmapped). Go to ACCESS.
- **Arbitration (default): round-robin.**
  - When both requesters are active, the one not equal to `last_gnt` wins.
  - `last_gnt` updates on each grant. It resets to 1, so m0 wins the first tie.
- **ACCESS**
  - `mem_addr` = latched address.
  - Read in ROM/RAM: `mem_oe`=1 for every ACCESS cycle.
  - Write to RAM: `mem_data` is driven with the latched wdata for every ACCESS cycle. `mem_we`=1 only in the final ACCESS cycle (counter==0), so exactly one write edge occurs.
  - The counter decrements each cycle. At counter==0: sample `mem_data` into the rdata register on reads, then go to RESP.
- **Fault cases** (still pass through ACCESS for one cycle, with `mem_oe`, `mem_we` and the `mem_data` drive all suppressed):
  - Write to ROM.
  - Any access to `addr[31:27]!=0` (unmapped).
  - Unmapped reads return rdata=0.
- **RESP**
  - `m{cur}_ack`=1 and `m{cur}_rdata`=latched data. `bus_err`=1 if the transaction faulted. The other ack stays 0.
  - Next state is IDLE.
- `mem_data` is high-Z in every state except write-ACCESS to RAM.
- Non-granted requesters wait; their req must stay asserted.

## Timing
- Reset values:
  - State IDLE; `last_gnt`=1.
  - `m0_ack`=`m1_ack`=`bus_err`=0.
  - `m0_rdata`=`m1_rdata`=0.
  - `mem_oe`=`mem_we`=0, `mem_addr`=0, `mem_data` high-Z.
- Latency, with req sampled high in IDLE cycle t and W = region wait:
  - ACCESS occupies cycles t+1 … t+1+W.
  - Ack is high in cycle t+2+W.
  - Minimum transaction: 3 cycles. A requester holding req continuously gets back-to-back service every 3+W cycles.
- Requester handshake:
  - A transaction is complete at the rising edge where ack=1.
  - The requester may change or drop req/addr/we/wdata on that edge.
  - A req dropped before ack is a protocol violation; the arbiter still completes the transaction.
- Simultaneous requests in IDLE are resolved in the same cycle. There is no combinational req→ack path.
- Reset mid-ACCESS or mid-RESP:
  - Abort the transaction; return to IDLE on the reset edge.
  - No `mem_we` is asserted after that edge, and no ack is issued.
- Wait-counter width is 4 bits. Region is decoded from the latched address only.

## Configuration
- `RISKY_ARB_FIXED_PRIO_EN`
  - **Defined:** fixed priority, m0 always wins ties. `last_gnt` is not used, and m1 can starve while m0 holds req.
  - **Undefined (default):** round-robin as described above.
  - All other behaviour and timing are identical in both modes.

## Test plan
- m0 read of ROM addr 0x00000004 holding 0xDEADBEEF, `ROM_WAIT`=1, req in cycle 0 → `mem_oe` high in cycles 1–2, `m0_ack`=1 with rdata 0xDEADBEEF in cycle 3, `bus_err`=0.
- m1 write 0x12345678 to 0x04000010, `RAM_WAIT`=0 → single `mem_we` pulse in cycle 1, ack in cycle 2. A subsequent m1 read of the same address returns 0x12345678.
- m0 and m1 both hold reads continuously (default build) → grants alternate m0, m1, m0, m1; acks never overlap; `mem_data` is never driven by the arbiter.
- m0 write to ROM 0x00000008 → `mem_we` stays 0, `m0_ack`=1 and `bus_err`=1 in the same cycle. Read of 0x08000000 → rdata=0, `bus_err`=1.
- `rst` asserted during the first ACCESS cycle of a RAM write with `RAM_WAIT`=3 → no `mem_we` pulse, no ack, all outputs at reset values next cycle, RAM word unchanged.
- With `RISKY_ARB_FIXED_PRIO_EN` defined and both reqs held for 4 transactions → m0 acked 4 times, m1 never; m1 is acked first after m0 drops req.
